// File: rtl/dtb_pkg.sv
// Shared trace-buffer parameters and the serializer state type.
package dtb_pkg;

    localparam int TRB_WIDTH        = 32;
    localparam int TRB_MAX_TRACES   = 8;
    localparam int TRB_LANES_LOG2_W = $clog2($clog2(TRB_MAX_TRACES) + 1);

    typedef enum logic {
        SER_IDLE  = 1'b0,
        SER_SHIFT = 1'b1
    } ser_state_e;

endpackage

// File: rtl/trb_lane_select.sv
// Masks the low lanes of the word shift register down to the active lane count.
module trb_lane_select
    import dtb_pkg::*;
#(
    parameter int MAX_TRACES = TRB_MAX_TRACES,
    parameter int LOG_W      = TRB_LANES_LOG2_W
) (
    input  logic [MAX_TRACES-1:0] lanes_in,
    input  logic [LOG_W-1:0]      lanes_log2,
    output logic [MAX_TRACES-1:0] beat
);

    // Lanes at or above 2**lanes_log2 are forced to zero.
    always_comb begin
        beat = '0;
        for (int i = 0; i < MAX_TRACES; i++) begin
            beat[i] = (i < int'(32'd1 << lanes_log2)) ? lanes_in[i] : 1'b0;
        end
    end

endmodule

// File: rtl/trb_stream_serializer.sv
// Word-to-lane-beat serializer for the trace stream port.
// Optional underflow monitor enabled by macro STB_SER_UNDERFLOW_EN.
module trb_stream_serializer
    import dtb_pkg::*;
#(
    parameter int WIDTH      = TRB_WIDTH,
    parameter int MAX_TRACES = TRB_MAX_TRACES,
    parameter int LOG_W      = $clog2($clog2(MAX_TRACES) + 1)
) (
    input  logic                  CLK_I,
    input  logic                  RST_NI,
    input  logic [LOG_W-1:0]      CONF_LANES_LOG2_I,
    input  logic                  DATA_VALID_I,
    output logic                  DATA_READY_O,
    input  logic [WIDTH-1:0]      DATA_I,
    input  logic                  READ_I,
    output logic                  STREAM_VALID_O,
    output logic [MAX_TRACES-1:0] STREAM_O,
    output logic                  STREAM_LAST_O
`ifdef STB_SER_UNDERFLOW_EN
    ,
    output logic                  UNDERFLOW_O,
    output logic [15:0]           UNDERFLOW_CNT_O
`endif
);

    localparam int               LANES_LOG2_MAX = $clog2(MAX_TRACES);
    localparam int               CNT_W          = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_ONE        = CNT_W'(1);

    function automatic logic [LOG_W-1:0] sat_log2(input logic [LOG_W-1:0] conf);
        if (int'(conf) > LANES_LOG2_MAX) begin
            return LOG_W'(LANES_LOG2_MAX);
        end else begin
            return conf;
        end
    endfunction

    function automatic logic [CNT_W-1:0] last_beat_idx(input logic [LOG_W-1:0] lg);
        return CNT_W'(WIDTH >> lg) - CNT_ONE;
    endfunction

    ser_state_e            state_r, state_n;
    logic [WIDTH-1:0]      shreg_r, shreg_n;
    logic [LOG_W-1:0]      lanes_r, lanes_n;
    logic [CNT_W-1:0]      beat_r, beat_n;
    logic                  valid_r, valid_n;
    logic                  last_r, last_n;
    logic [MAX_TRACES-1:0] stream_r, stream_n;
    logic [MAX_TRACES-1:0] beat_sel_s;
    logic                  accept_s;
    logic                  consume_s;

    // Ready is combinational on READ_I so a new word can follow the last beat with no bubble.
    assign DATA_READY_O   = (state_r == SER_IDLE) | (last_r & READ_I);
    assign accept_s       = DATA_VALID_I & DATA_READY_O;
    assign consume_s      = valid_r & READ_I;
    assign STREAM_VALID_O = valid_r;
    assign STREAM_O       = stream_r;
    assign STREAM_LAST_O  = last_r;

    trb_lane_select #(
        .MAX_TRACES (MAX_TRACES),
        .LOG_W      (LOG_W)
    ) u_lane_select (
        .lanes_in   (shreg_n[MAX_TRACES-1:0]),
        .lanes_log2 (lanes_n),
        .beat       (beat_sel_s)
    );

    // Next-state: accept a word, advance one beat, or hold.
    always_comb begin
        state_n = state_r;
        shreg_n = shreg_r;
        lanes_n = lanes_r;
        beat_n  = beat_r;
        valid_n = valid_r;
        last_n  = last_r;
        if (accept_s) begin
            state_n = SER_SHIFT;
            shreg_n = DATA_I;
            lanes_n = sat_log2(CONF_LANES_LOG2_I);
            beat_n  = '0;
            valid_n = 1'b1;
            last_n  = (last_beat_idx(lanes_n) == '0);
        end else if (consume_s && last_r) begin
            state_n = SER_IDLE;
            beat_n  = '0;
            valid_n = 1'b0;
            last_n  = 1'b0;
        end else if (consume_s) begin
            shreg_n = shreg_r >> (32'd1 << lanes_r);
            beat_n  = beat_r + CNT_ONE;
            last_n  = (beat_n == last_beat_idx(lanes_r));
        end else begin
            state_n = state_r;
            valid_n = valid_r;
        end
        stream_n = valid_n ? beat_sel_s : '0;
    end

    // Control, word storage and registered stream outputs.
    always_ff @(posedge CLK_I) begin
        if (!RST_NI) begin
            state_r  <= SER_IDLE;
            shreg_r  <= '0;
            lanes_r  <= '0;
            beat_r   <= '0;
            valid_r  <= 1'b0;
            last_r   <= 1'b0;
            stream_r <= '0;
        end else begin
            state_r  <= state_n;
            shreg_r  <= shreg_n;
            lanes_r  <= lanes_n;
            beat_r   <= beat_n;
            valid_r  <= valid_n;
            last_r   <= last_n;
            stream_r <= stream_n;
        end
    end

`ifdef STB_SER_UNDERFLOW_EN
    logic        underflow_r;
    logic [15:0] underflow_cnt_r;

    assign UNDERFLOW_O     = underflow_r;
    assign UNDERFLOW_CNT_O = underflow_cnt_r;

    // Sticky flag and saturating count of pulls with no beat available.
    always_ff @(posedge CLK_I) begin
        if (!RST_NI) begin
            underflow_r     <= 1'b0;
            underflow_cnt_r <= 16'd0;
        end else if (READ_I && !valid_r) begin
            underflow_r     <= 1'b1;
            underflow_cnt_r <= (underflow_cnt_r == 16'hFFFF) ? underflow_cnt_r
                                                              : underflow_cnt_r + 16'd1;
        end else begin
            underflow_r     <= underflow_r;
            underflow_cnt_r <= underflow_cnt_r;
        end
    end
`else
    // Without the monitor, a pull with no valid beat simply has no effect.
`endif

endmodule

// File: tb/tb_trb_stream_serializer.sv
// Directed and random checks of trb_stream_serializer against a beat-queue model.
module tb_trb_stream_serializer;

    logic        clk;
    logic        rst_n;
    logic [1:0]  conf;
    logic        dv;
    logic        ready;
    logic [31:0] data;
    logic        rd;
    logic        svalid;
    logic [7:0]  sdata;
    logic        slast;
`ifdef STB_SER_UNDERFLOW_EN
    logic        uf;
    logic [15:0] ufcnt;
`endif

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_v[$];
    bit         exp_l[$];
    bit         m_uf;
    int         m_ufcnt;

    trb_stream_serializer dut (
        .CLK_I             (clk),
        .RST_NI            (rst_n),
        .CONF_LANES_LOG2_I (conf),
        .DATA_VALID_I      (dv),
        .DATA_READY_O      (ready),
        .DATA_I            (data),
        .READ_I            (rd),
        .STREAM_VALID_O    (svalid),
        .STREAM_O          (sdata),
        .STREAM_LAST_O     (slast)
`ifdef STB_SER_UNDERFLOW_EN
        ,
        .UNDERFLOW_O       (uf),
        .UNDERFLOW_CNT_O   (ufcnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected beats of one word: lane group k of width L, LSB first.
    task automatic push_word(input logic [31:0] w, input logic [1:0] c);
        int lg;
        int lanes;
        int beats;
        lg    = (int'(c) > 3) ? 3 : int'(c);
        lanes = 1 << lg;
        beats = 32 / lanes;
        for (int k = 0; k < beats; k++) begin
            exp_v.push_back(8'((w >> (k * lanes)) & ((32'd1 << lanes) - 32'd1)));
            exp_l.push_back(k == beats - 1);
        end
    endtask

    task automatic step(input bit r, input bit v, input logic [31:0] d, input bit rdi,
                        input logic [1:0] c);
        bit exp_ready;
        bit do_pop;
        bit do_push;
        rst_n = r;
        dv    = v;
        data  = d;
        rd    = rdi;
        conf  = c;
        #1;
        if (exp_v.size() == 0) exp_ready = 1'b1;
        else                   exp_ready = exp_l[0] && rdi;
        if (r) check("ready", {31'd0, ready}, {31'd0, exp_ready});
        do_pop  = (exp_v.size() != 0) && rdi;
        do_push = v && exp_ready;
        @(posedge clk);
        if (!r) begin
            exp_v.delete();
            exp_l.delete();
            m_uf    = 1'b0;
            m_ufcnt = 0;
        end else begin
            if (rdi && exp_v.size() == 0) begin
                m_uf    = 1'b1;
                m_ufcnt = (m_ufcnt == 65535) ? m_ufcnt : m_ufcnt + 1;
            end
            if (do_pop) begin
                void'(exp_v.pop_front());
                void'(exp_l.pop_front());
            end
            if (do_push) push_word(d, c);
        end
        #1;
        check("valid", {31'd0, svalid}, {31'd0, exp_v.size() != 0});
        check("stream", {24'd0, sdata}, (exp_v.size() != 0) ? {24'd0, exp_v[0]} : 32'd0);
        check("last", {31'd0, slast}, {31'd0, (exp_v.size() != 0) ? exp_l[0] : 1'b0});
`ifdef STB_SER_UNDERFLOW_EN
        check("underflow", {31'd0, uf}, {31'd0, m_uf});
        check("underflow_cnt", {16'd0, ufcnt}, 32'(m_ufcnt));
`endif
    endtask

    initial begin
        rst_n = 1'b0; dv = 1'b0; data = 32'd0; rd = 1'b0; conf = 2'd0;
        m_uf = 1'b0; m_ufcnt = 0;

        step(1'b0, 1'b0, 32'd0, 1'b0, 2'd0);
        step(1'b0, 1'b0, 32'd0, 1'b0, 2'd0);
        check("reset_valid", {31'd0, svalid}, 32'd0);
        check("reset_stream", {24'd0, sdata}, 32'd0);

        // Pulls while idle, then hold.
        repeat (3) step(1'b1, 1'b0, 32'd0, 1'b1, 2'd3);
        repeat (2) step(1'b1, 1'b0, 32'd0, 1'b0, 2'd3);

        // Full-width beats, READ_I held high.
        step(1'b1, 1'b1, 32'h87654321, 1'b1, 2'd3);
        check("first_beat", {24'd0, sdata}, 32'h21);
        repeat (4) step(1'b1, 1'b0, 32'd0, 1'b1, 2'd3);

        // Single-lane beats.
        step(1'b1, 1'b1, 32'h00000005, 1'b1, 2'd0);
        repeat (32) step(1'b1, 1'b0, 32'd0, 1'b1, 2'd0);

        // Back-to-back nibble words.
        step(1'b1, 1'b1, 32'hAAAA5555, 1'b1, 2'd2);
        repeat (7) step(1'b1, 1'b0, 32'd0, 1'b1, 2'd2);
        step(1'b1, 1'b1, 32'h12345678, 1'b1, 2'd2);
        check("b2b_first", {24'd0, sdata}, 32'h8);
        repeat (8) step(1'b1, 1'b0, 32'd0, 1'b1, 2'd2);

        // Toggling READ_I with CONF changing mid-word and a pending next word.
        step(1'b1, 1'b1, 32'hCAFEF00D, 1'b0, 2'd3);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, 32'h0BADBEEF, (i % 2) == 0, 2'(i));
        end
        repeat (40) step(1'b1, 1'b0, 32'd0, 1'b1, 2'd1);

        // Reset mid-word, then a fresh word.
        step(1'b1, 1'b1, 32'hA1B2C3D4, 1'b1, 2'd3);
        step(1'b1, 1'b0, 32'd0, 1'b1, 2'd3);
        step(1'b0, 1'b0, 32'd0, 1'b0, 2'd3);
        step(1'b1, 1'b1, 32'h55667788, 1'b1, 2'd3);
        check("after_reset_beat0", {24'd0, sdata}, 32'h88);
        repeat (4) step(1'b1, 1'b0, 32'd0, 1'b1, 2'd3);

        // Random traffic with occasional resets.
        repeat (600) begin
            step(1'($urandom_range(0, 49) != 0), 1'($urandom_range(0, 1)), $urandom,
                 1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
